activation_streamer: RTL

//  Feeder for the sliding-window convolver. Holds one n x n activation map in a local

---
 rtl/activation_streamer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/activation_streamer.sv
// ============================================================================
// activation_streamer: buffers one n x n activation map and streams it in raster
// order to the sliding-window convolver, then pads with zeros until end_conv.
// Revision: 1.0
// ============================================================================
`default_nettype none

module activation_streamer #(
    parameter int N         = 16,
    parameter int MAP_N     = 10,
    parameter int AW        = 7,
    parameter int DRAIN_MAX = 4
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          start,
    input  logic          stall,
    input  logic          end_conv_in,
    output logic [N-1:0]  act_out,
    output logic          ce_out,
    output logic          conv_clr,
    output logic          busy,
    output logic          done,
    output logic          err_timeout
);

    localparam int              DEPTH = MAP_N * MAP_N;
    localparam logic [AW-1:0]   LAST  = AW'(DEPTH - 1);
    localparam int              DCW   = $clog2(DRAIN_MAX + 1);
    localparam logic [DCW-1:0]  DMAX  = DCW'(DRAIN_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [N-1:0]    act_q, act_d;
    logic            ce_q, ce_d;
    logic            clr_q, clr_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [N-1:0]    mem_q [DEPTH];
    logic [N-1:0]    rd_data_q;
    logic [AW-1:0]   rd_addr;
    logic            mem_we;
    logic [DCW-1:0]  drain_inc;

    // Writes are only accepted while idle, so the map is frozen during a stream.
    assign mem_we    = (state_q == S_IDLE) && wr_en && (wr_addr <= LAST);
    assign drain_inc = drain_q + DCW'(1);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            drain_q <= '0;
            act_q   <= '0;
            ce_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            drain_q <= drain_d;
            act_q   <= act_d;
            ce_q    <= ce_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        drain_d = drain_q;
        act_d   = act_q;
        ce_d    = 1'b0;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        rd_addr = ptr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    err_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                clr_d   = 1'b1;
                ptr_d   = '0;
                rd_addr = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // rd_data_q always holds buffer[ptr_q]; on advance, prefetch the next word.
                if (!stall) begin
                    act_d = rd_data_q;
                    ce_d  = 1'b1;
                    if (ptr_q == LAST) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        rd_addr = ptr_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                act_d = '0;
                if (end_conv_in) begin
                    state_d = S_DONE;
                end else if (!stall) begin
                    ce_d    = 1'b1;
                    drain_d = drain_inc;
                    if (drain_inc == DMAX) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                act_d   = '0;
                drain_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign act_out     = act_q;
    assign ce_out      = ce_q;
    assign conv_clr    = clr_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire
